// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
// Holds RV32I load/store funct3 encodings, FSM states and the counter width helper.
package riscv_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitR,
    StDone
  } mem_state_e;

  // Never narrower than one bit so tiny timeouts still elaborate.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/gnt/rvalid bus; master is the load/store unit, slave is the memory.
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );

endinterface

// File: rtl/load_formatter.sv
// Selects the addressed byte/half/word lane of a read word and sign- or zero-extends it.
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = '0;
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data = {24'h000000, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LHU:     o_data = {16'h0000, w_half};
      LW:      o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one bus access per instruction, stalls until it completes,
// and registers the formatted load result for the following WB cycle.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_mem_valid,
  input  logic              i_ex_mem_load,
  input  logic              i_ex_mem_store,
  input  logic [2:0]        i_ex_mem_funct3,
  input  logic [31:0]       i_ex_mem_addr,
  input  logic [31:0]       i_ex_mem_store_data,
  output logic [31:0]       o_mem_read_data,
  output logic              o_mem_stall,
  output logic              o_mem_misaligned,
  output logic              o_mem_bus_error,
  mem_access_unit_if.master dmem
);

  localparam int unsigned     CntW    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  mem_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_read_data;

  logic        w_is_mem, w_ld_legal, w_st_legal, w_aligned, w_pending, w_bad, w_timeout;
  logic        w_req, w_stall, w_mis, w_err, w_cnt_clr, w_capture, w_clear_rd;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_fmt;

  always_comb begin
    w_is_mem   = i_ex_mem_valid & (i_ex_mem_load | i_ex_mem_store);
    w_ld_legal = i_ex_mem_funct3 inside {LB, LH, LW, LBU, LHU};
    w_st_legal = i_ex_mem_funct3 inside {SB, SH, SW};
    unique case (i_ex_mem_funct3[1:0])
      2'b01:   w_aligned = ~i_ex_mem_addr[0];
      2'b10:   w_aligned = (i_ex_mem_addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    w_pending = w_is_mem & (~i_ex_mem_load | w_ld_legal) & (~i_ex_mem_store | w_st_legal)
              & w_aligned;
    w_bad     = w_is_mem & ~w_pending;
    w_timeout = (r_cnt == CntLast);
  end

  always_comb begin
    unique case (i_ex_mem_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_ex_mem_addr[1:0];
        w_wdata = {4{i_ex_mem_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = i_ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_ex_mem_store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_ex_mem_store_data;
      end
    endcase
  end

  load_formatter u_load_formatter (
    .i_rdata   (dmem.dmem_rdata),
    .i_addr_lo (i_ex_mem_addr[1:0]),
    .i_funct3  (i_ex_mem_funct3),
    .o_data    (w_fmt)
  );

  always_comb begin
    w_state_d  = r_state;
    w_req      = 1'b0;
    w_stall    = 1'b0;
    w_mis      = 1'b0;
    w_err      = 1'b0;
    w_cnt_clr  = 1'b0;
    w_capture  = 1'b0;
    w_clear_rd = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_pending) begin
          w_req     = 1'b1;
          w_stall   = 1'b1;
          w_cnt_clr = 1'b1;
          if (dmem.dmem_gnt) w_state_d = i_ex_mem_load ? StWaitR : StDone;
          else               w_state_d = StReq;
        end else if (w_bad) begin
          w_mis      = 1'b1;
          w_clear_rd = i_ex_mem_load;
        end
      end
      StReq: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem.dmem_gnt) begin
          w_cnt_clr = 1'b1;
          w_state_d = i_ex_mem_load ? StWaitR : StDone;
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_clear_rd = i_ex_mem_load;
          w_state_d  = StDone;
        end
      end
      StWaitR: begin
        w_stall = 1'b1;
        if (dmem.dmem_rvalid) begin
          w_capture = 1'b1;
          w_state_d = StDone;
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_clear_rd = 1'b1;
          w_state_d  = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // The state register may still hold a mid-access state during the reset cycle.
    if (i_rst) begin
      w_req   = 1'b0;
      w_stall = 1'b0;
      w_mis   = 1'b0;
      w_err   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state == StReq || r_state == StWaitR) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_read_data <= w_fmt;
      end else if (w_clear_rd) begin
        r_read_data <= '0;
      end
    end
  end

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = w_req & i_ex_mem_store;
  assign dmem.dmem_addr  = w_req ? {i_ex_mem_addr[31:2], 2'b00} : 32'h0;
  assign dmem.dmem_be    = w_req ? w_be : 4'b0000;
  assign dmem.dmem_wdata = w_req ? w_wdata : 32'h0;

  assign o_mem_read_data  = r_read_data;
  assign o_mem_stall      = w_stall;
  assign o_mem_misaligned = w_mis;
  assign o_mem_bus_error  = w_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of accesses with a responding memory model,
// a read-data scoreboard, and hand sequences for idle, reset and late-response cases.
module tb_mem_access_unit;
  import riscv_mem_pkg::*;

  typedef struct {
    string       name;
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    int          exp_stalls;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    bit          exp_mis;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ld, st;
  logic [2:0]  f3;
  logic [31:0] addr, sdata;
  logic [31:0] rd;
  logic        stall, mis, err;

  logic [31:0] ref_rdata;
  logic [1:0]  ref_lo;
  logic [2:0]  ref_f3;
  logic [31:0] ref_out;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_rd;
  logic [31:0] sb_q[$];
  vec_t        vecs[$];

  mem_access_unit_if bus ();

  mem_access_unit #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ex_mem_valid      (valid),
    .i_ex_mem_load       (ld),
    .i_ex_mem_store      (st),
    .i_ex_mem_funct3     (f3),
    .i_ex_mem_addr       (addr),
    .i_ex_mem_store_data (sdata),
    .o_mem_read_data     (rd),
    .o_mem_stall         (stall),
    .o_mem_misaligned    (mis),
    .o_mem_bus_error     (err),
    .dmem                (bus)
  );

  load_formatter u_ref (
    .i_rdata   (ref_rdata),
    .i_addr_lo (ref_lo),
    .i_funct3  (ref_f3),
    .o_data    (ref_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(string name, bit l, bit s, logic [2:0] fn, logic [31:0] a,
                              logic [31:0] w, int gd, int rvd, logic [31:0] rdat,
                              logic [31:0] erd, int est, logic [3:0] ebe, logic [31:0] ewd,
                              bit emis, bit eerr);
    vec_t v;
    v.name = name; v.ld = l; v.st = s; v.f3 = fn; v.addr = a; v.wd = w;
    v.gnt_dly = gd; v.rv_dly = rvd; v.rdata = rdat; v.exp_rd = erd; v.exp_stalls = est;
    v.exp_be = ebe; v.exp_wdata = ewd; v.exp_mis = emis; v.exp_err = eerr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int          stalls = 0, errs = 0, miss = 0, k = 0, j = 0, phase = 0;
    bit          done = 1'b0, bus_bad = 1'b0;
    logic [31:0] exp_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    valid = 1'b1; ld = v.ld; st = v.st; f3 = v.f3; addr = v.addr; sdata = v.wd;
    if (v.ld) last_rd = v.exp_rd;
    sb_q.push_back(last_rd);
    for (int c = 0; c < 64; c++) begin
      bus.dmem_gnt    = (phase == 0) && (k == v.gnt_dly);
      bus.dmem_rvalid = (phase == 1) && (j == v.rv_dly);
      bus.dmem_rdata  = bus.dmem_rvalid ? v.rdata : 32'h5A5A5A5A;
      #1;
      errs += int'(err);
      miss += int'(mis);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (bus.dmem_req) begin
        if (phase != 0 || bus.dmem_addr !== exp_addr || bus.dmem_we !== v.st) bus_bad = 1'b1;
        if (v.st && (bus.dmem_be !== v.exp_be || bus.dmem_wdata !== v.exp_wdata)) bus_bad = 1'b1;
      end else if (phase == 0 || bus.dmem_we || bus.dmem_addr != 0 || bus.dmem_be != 0
                   || bus.dmem_wdata != 0) begin
        bus_bad = 1'b1;
      end
      @(posedge clk);
      if (phase == 0) begin
        if (bus.dmem_gnt) phase = v.ld ? 1 : 2;
        else k++;
      end else if (phase == 1) begin
        if (bus.dmem_rvalid) phase = 2;
        else j++;
      end
      @(negedge clk);
    end
    chk({v.name, "_done"}, 32'(done), 32'd1);
    chk({v.name, "_end_req"}, 32'(bus.dmem_req), 32'd0);
    chk({v.name, "_stalls"}, stalls, v.exp_stalls);
    chk({v.name, "_bus"}, 32'(bus_bad), 32'd0);
    chk({v.name, "_mis"}, miss, 32'(v.exp_mis));
    chk({v.name, "_err"}, errs, 32'(v.exp_err));
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; ld = 1'b0; st = 1'b0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    #1;
    if (sb_q.size() == 0) begin
      chk({v.name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      chk({v.name, "_rd_wb"}, rd, sb_q.pop_front());
    end
    @(negedge clk);
    #1;
    chk({v.name, "_rd_hold"}, rd, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] ld_ops[5];
    ld_ops[0] = LB; ld_ops[1] = LH; ld_ops[2] = LW; ld_ops[3] = LBU; ld_ops[4] = LHU;

    //             name          ld st f3    addr          wdata         gd rv rdata
    //             exp_rd        stl be       exp_wdata     mis err
    vecs.push_back(mk("lw_basic", 1, 0, LW, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
                      32'hDEADBEEF, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lb_neg", 1, 0, LB, 32'h103, 32'h0, 0, 0, 32'h80FF1234,
                      32'hFFFFFF80, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lbu", 1, 0, LBU, 32'h103, 32'h0, 0, 0, 32'h80FF1234,
                      32'h00000080, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lhu", 1, 0, LHU, 32'h102, 32'h0, 0, 0, 32'h80FF1234,
                      32'h000080FF, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lh_neg", 1, 0, LH, 32'h102, 32'h0, 0, 0, 32'h80FF1234,
                      32'hFFFF80FF, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lh_lo", 1, 0, LH, 32'h100, 32'h0, 0, 0, 32'h80FF1234,
                      32'h00001234, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lb_b1", 1, 0, LB, 32'h101, 32'h0, 0, 0, 32'h0000A500,
                      32'hFFFFFFA5, 2, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("sh_slow", 0, 1, SH, 32'h206, 32'h0000ABCD, 3, 0, 32'h0,
                      32'h0, 4, 4'b1100, 32'hABCDABCD, 0, 0));
    vecs.push_back(mk("sb", 0, 1, SB, 32'h201, 32'h12345678, 0, 0, 32'h0,
                      32'h0, 1, 4'b0010, 32'h78787878, 0, 0));
    vecs.push_back(mk("sw", 0, 1, SW, 32'h200, 32'hCAFEF00D, 1, 0, 32'h0,
                      32'h0, 2, 4'b1111, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk("lw_slow", 1, 0, LW, 32'h104, 32'h0, 2, 3, 32'h13572468,
                      32'h13572468, 7, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("lw_mis", 1, 0, LW, 32'h101, 32'h0, 0, 0, 32'h0,
                      32'h0, 0, 4'b0000, 32'h0, 1, 0));
    vecs.push_back(mk("lw_rv1", 1, 0, LW, 32'h108, 32'h0, 0, 1, 32'h0F0F0F0F,
                      32'h0F0F0F0F, 3, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("ld_tmo", 1, 0, LW, 32'h10C, 32'h0, 0, -1, 32'h0,
                      32'h0, 17, 4'b0000, 32'h0, 0, 1));
    vecs.push_back(mk("lhu_hi", 1, 0, LHU, 32'h10E, 32'h0, 1, 0, 32'hBEEF1111,
                      32'h0000BEEF, 3, 4'b0000, 32'h0, 0, 0));
    vecs.push_back(mk("st_tmo", 0, 1, SW, 32'h200, 32'h11223344, -1, 0, 32'h0,
                      32'h0, 17, 4'b1111, 32'h11223344, 0, 1));
    vecs.push_back(mk("ld_bad_f3", 1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0,
                      32'h0, 0, 4'b0000, 32'h0, 1, 0));

    rst = 1'b1; valid = 1'b0; ld = 1'b0; st = 1'b0; f3 = 3'b000; addr = '0; sdata = '0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    ref_rdata = '0; ref_lo = '0; ref_f3 = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rd", rd, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_pulses", 32'({mis, err}), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Random loads, expected data from the reference formatter.
    for (int i = 0; i < 6; i++) begin
      vec_t       v;
      logic [2:0] fn;
      logic [1:0] lo;
      int         gd, rvd;
      fn = ld_ops[$urandom_range(0, 4)];
      lo = 2'($urandom_range(0, 3));
      if (fn == LW) lo = 2'b00;
      else if (fn[1:0] == 2'b01) lo[0] = 1'b0;
      gd  = $urandom_range(0, 2);
      rvd = $urandom_range(0, 2);
      ref_rdata = $urandom; ref_lo = lo; ref_f3 = fn;
      #1;
      v = mk("rand_ld", 1, 0, fn, {28'h000040, 2'b00, lo}, 32'h0, gd, rvd, ref_rdata,
             ref_out, gd + rvd + 2, 4'b0000, 32'h0, 0, 0);
      run_vec(v);
    end

    run_vec(mk("pre_idle", 1, 0, LW, 32'h310, 32'h0, 0, 0, 32'h11112222,
               32'h11112222, 2, 4'b0000, 32'h0, 0, 0));
    // valid low: responses must be ignored and nothing issued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'b0; ld = 1'b1; st = 1'b1; f3 = LW; addr = 32'h100;
      bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_req", 32'(bus.dmem_req), 32'd0);
    end
    @(negedge clk);
    ld = 1'b0; st = 1'b0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    #1;
    chk("idle_rd_kept", rd, 32'h11112222);

    // Reset while waiting for rvalid, then a late rvalid.
    @(negedge clk);
    valid = 1'b1; ld = 1'b1; f3 = LW; addr = 32'h300; bus.dmem_gnt = 1'b1;
    #1;
    chk("mid_req", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    #1;
    chk("mid_wait_stall", 32'(stall), 32'd1);
    rst = 1'b1; valid = 1'b0; ld = 1'b0;
    #1;
    chk("rst_hi_stall", 32'(stall), 32'd0);
    chk("rst_hi_req", 32'(bus.dmem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hBADBAD00;
    #1;
    chk("post_rst_rd", rd, 32'h0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_ign", rd, 32'h0);
    last_rd = '0;
    run_vec(mk("lw_after_rst", 1, 0, LW, 32'h304, 32'h0, 0, 0, 32'h600DF00D,
               32'h600DF00D, 2, 4'b0000, 32'h0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
